// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receiver (5-8 data bits, none/even/odd parity, 1-2 stop
//            bits, runtime bit period) feeding a first-word-fall-through
//            FIFO drained by a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          rx,
  input  logic [15:0]                   baud_div,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_ferr,
  output logic                          rd_perr,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          busy
);

  localparam int                c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int                c_WORD_W = DATA_BITS + 2;
  localparam logic [c_ADDR_W:0] c_FULL   = (c_ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [2:0]        c_DLAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]        c_SLAST  = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

  // ---------------------------------------------------------------- sync
  logic       r_rx_meta, r_rx_sync, r_rx_prev;
  // Marks which sync stages hold genuine line samples rather than reset
  // values, so a line that is already low at reset exit is not an edge.
  logic [2:0] r_smp_vld;
  logic       w_fall;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_smp_vld <= 3'b000;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_smp_vld <= {r_smp_vld[1:0], 1'b1};
    end
  end

  assign w_fall = r_smp_vld[2] & r_rx_prev & ~r_rx_sync;

  // ---------------------------------------------------------------- FSM
  state_t                 r_state, w_state_nxt;
  logic [15:0]            r_bdiv, w_bdiv_nxt;
  logic [15:0]            r_cnt, w_cnt_nxt;
  logic [2:0]             r_bitn, w_bitn_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   r_ferr, w_ferr_nxt;
  logic                   r_perr, w_perr_nxt;
  logic                   w_tick, w_push, w_par_x;
  logic [15:0]            w_reload;

  assign w_tick   = (r_cnt == 16'd0);
  assign w_reload = r_bdiv - 16'd1;
  assign w_par_x  = (^r_shift) ^ r_rx_sync;

  // Receiver state and datapath registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= IDLE;
      r_bdiv  <= 16'd0;
      r_cnt   <= 16'd0;
      r_bitn  <= 3'd0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bdiv  <= w_bdiv_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bitn  <= w_bitn_nxt;
      r_shift <= w_shift_nxt;
      r_ferr  <= w_ferr_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  // Next-state logic; every counting state reloads the bit counter on a
  // sample point and decrements it otherwise.
  always_comb begin
    w_state_nxt = r_state;
    w_bdiv_nxt  = r_bdiv;
    w_cnt_nxt   = r_cnt;
    w_bitn_nxt  = r_bitn;
    w_shift_nxt = r_shift;
    w_ferr_nxt  = r_ferr;
    w_perr_nxt  = r_perr;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_bdiv_nxt  = baud_div;
          w_cnt_nxt   = baud_div >> 1;
          w_bitn_nxt  = 3'd0;
          w_ferr_nxt  = 1'b0;
          w_perr_nxt  = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_tick) begin
          w_cnt_nxt   = w_reload;
          w_state_nxt = r_rx_sync ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = w_reload;
          w_shift_nxt = {r_rx_sync, r_shift[DATA_BITS-1:1]};
          if (r_bitn == c_DLAST) begin
            w_bitn_nxt  = 3'd0;
            w_state_nxt = (PARITY != 0) ? PAR : STOP;
          end else begin
            w_bitn_nxt = r_bitn + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      PAR: begin
        if (w_tick) begin
          w_cnt_nxt   = w_reload;
          w_perr_nxt  = (PARITY == 1) ? w_par_x : ~w_par_x;
          w_state_nxt = STOP;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_cnt_nxt  = w_reload;
          w_ferr_nxt = r_ferr | ~r_rx_sync;
          if (r_bitn == c_SLAST) begin
            w_push      = 1'b1;
            w_bitn_nxt  = 3'd0;
            w_state_nxt = r_rx_sync ? IDLE : WAIT_HI;
          end else begin
            w_bitn_nxt = r_bitn + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      WAIT_HI: begin
        if (r_rx_sync) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  // ---------------------------------------------------------------- FIFO
  logic [c_WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wptr, r_rptr;
  logic [c_ADDR_W:0]   r_count;
  logic                r_overrun;
  logic                w_full, w_pop, w_wr, w_ovf;
  logic [c_WORD_W-1:0] w_word, w_head;

  // The frame's ferr includes the final stop sample being taken this cycle.
  assign w_word = {r_ferr | ~r_rx_sync, r_perr, r_shift};
  assign w_full = (r_count == c_FULL);
  assign w_pop  = rd_valid & rd_ready;
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_ovf  = w_push & w_full & ~w_pop;

  // Pointers, occupancy and the sticky overrun flag (set beats clear).
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      if (w_ovf)            r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (w_wr) r_mem[r_wptr] <= w_word;
  end

  assign w_head   = r_mem[r_rptr];
  assign rd_valid = (r_count != '0);
  assign rd_data  = rd_valid ? w_head[DATA_BITS-1:0] : '0;
  assign rd_perr  = rd_valid & w_head[DATA_BITS];
  assign rd_ferr  = rd_valid & w_head[DATA_BITS+1];
  assign count    = r_count;
  assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed bench for uart_rx_fifo; four instances cover 8N1,
//            7E1, 8N2 and a 4-deep FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [15:0] baud_div = 16'd10;
  logic        clr_overrun = 1'b0;
  logic [3:0]  rx_line;
  logic [3:0]  rdy = 4'b0000;

  logic       v0, f0, p0, o0, b0;  logic [7:0] d0;  logic [3:0] c0;
  logic       v1, f1, p1, o1, b1;  logic [6:0] d1;  logic [3:0] c1;
  logic       v2, f2, p2, o2, b2;  logic [7:0] d2;  logic [3:0] c2;
  logic       v3, f3, p3, o3, b3;  logic [7:0] d3;  logic [2:0] c3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  uart_rx_fifo u0 (.HCLK(HCLK), .HRESET(HRESET), .rx(rx_line[0]), .baud_div(baud_div),
    .rd_valid(v0), .rd_ready(rdy[0]), .rd_data(d0), .rd_ferr(f0), .rd_perr(p0),
    .count(c0), .overrun(o0), .clr_overrun(clr_overrun), .busy(b0));

  uart_rx_fifo #(.DATA_BITS(7), .PARITY(1)) u1 (.HCLK(HCLK), .HRESET(HRESET),
    .rx(rx_line[1]), .baud_div(baud_div), .rd_valid(v1), .rd_ready(rdy[1]),
    .rd_data(d1), .rd_ferr(f1), .rd_perr(p1), .count(c1), .overrun(o1),
    .clr_overrun(clr_overrun), .busy(b1));

  uart_rx_fifo #(.STOP_BITS(2)) u2 (.HCLK(HCLK), .HRESET(HRESET), .rx(rx_line[2]),
    .baud_div(baud_div), .rd_valid(v2), .rd_ready(rdy[2]), .rd_data(d2),
    .rd_ferr(f2), .rd_perr(p2), .count(c2), .overrun(o2),
    .clr_overrun(clr_overrun), .busy(b2));

  uart_rx_fifo #(.FIFO_DEPTH(4)) u3 (.HCLK(HCLK), .HRESET(HRESET), .rx(rx_line[3]),
    .baud_div(baud_div), .rd_valid(v3), .rd_ready(rdy[3]), .rd_data(d3),
    .rd_ferr(f3), .rd_perr(p3), .count(c3), .overrun(o3),
    .clr_overrun(clr_overrun), .busy(b3));

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic drive_bit(input int inst, input logic b, input int bdiv);
    rx_line[inst] = b;
    repeat (bdiv) @(negedge HCLK);
  endtask

  // Serialise one character; call at a negative edge.
  task automatic send_frame(input int inst, input logic [7:0] data, input int db,
                            input int par, input bit flip, input int nstop,
                            input logic [1:0] stop_val, input int bdiv);
    logic [7:0] m;
    logic       p;
    m = 8'((1 << db) - 1);
    p = ^(data & m);
    if (par == 2) p = ~p;
    p = p ^ flip;
    drive_bit(inst, 1'b0, bdiv);
    for (int i = 0; i < db; i++) drive_bit(inst, data[i], bdiv);
    if (par != 0) drive_bit(inst, p, bdiv);
    for (int s = 0; s < nstop; s++) drive_bit(inst, stop_val[s], bdiv);
    rx_line[inst] = 1'b1;
  endtask

  task automatic pop(input int inst);
    rdy[inst] = 1'b1;
    @(negedge HCLK);
    rdy[inst] = 1'b0;
  endtask

  initial begin
    int k;
    rx_line = 4'b1101;                 // u1 line held low through reset
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;

    // Reset values
    check("rst_valid", v0, 0);
    check("rst_data", d0, 0);
    check("rst_ferr", f0, 0);
    check("rst_perr", p0, 0);
    check("rst_count", c0, 0);
    check("rst_overrun", o0, 0);
    check("rst_busy", b0, 0);

    // Line low at reset exit must not start a frame
    wait_cycles(30);
    check("lowrst_busy", b1, 0);
    check("lowrst_count", c1, 0);
    rx_line[1] = 1'b1;
    wait_cycles(5);

    // 8N1 0x41, latency from start edge to rd_valid
    k = -1;
    fork
      send_frame(0, 8'h41, 8, 0, 0, 1, 2'b11, 10);
      begin
        while (k < 200) begin
          @(posedge HCLK);
          k++;
          #1;
          if (v0) break;
        end
      end
    join
    check("8n1_latency", k, 98);
    wait_cycles(2);
    check("8n1_data", d0, 8'h41);
    check("8n1_ferr", f0, 0);
    check("8n1_perr", p0, 0);
    check("8n1_count", c0, 1);
    pop(0);
    check("8n1_drain_count", c0, 0);
    check("8n1_drain_valid", v0, 0);

    // 7E1 good and bad parity
    send_frame(1, 8'h35, 7, 1, 0, 1, 2'b11, 10);
    send_frame(1, 8'h35, 7, 1, 1, 1, 2'b11, 10);
    wait_cycles(3);
    check("7e1_count", c1, 2);
    check("7e1_d0", d1, 7'h35);
    check("7e1_perr0", p1, 0);
    check("7e1_ferr0", f1, 0);
    pop(1);
    check("7e1_d1", d1, 7'h35);
    check("7e1_perr1", p1, 1);
    pop(1);
    check("7e1_empty", c1, 0);

    // 8N2 with second stop bit low, then a break
    send_frame(2, 8'hA5, 8, 0, 0, 2, 2'b01, 10);
    wait_cycles(5);
    check("8n2_count", c2, 1);
    check("8n2_data", d2, 8'hA5);
    check("8n2_ferr", f2, 1);
    check("8n2_perr", p2, 0);
    check("8n2_busy", b2, 0);
    pop(2);
    wait_cycles(10);
    rx_line[2] = 1'b0;
    wait_cycles(990);
    check("brk_count", c2, 1);
    check("brk_data", d2, 0);
    check("brk_ferr", f2, 1);
    check("brk_busy", b2, 1);
    rx_line[2] = 1'b1;
    wait_cycles(20);
    check("brk_count_after", c2, 1);
    check("brk_busy_after", b2, 0);
    pop(2);
    check("brk_empty", c2, 0);

    // 4-deep FIFO overflow
    for (int i = 1; i <= 5; i++) send_frame(3, 8'(i), 8, 0, 0, 1, 2'b11, 10);
    wait_cycles(5);
    check("ovf_count", c3, 4);
    check("ovf_flag", o3, 1);
    check("ovf_head", d3, 8'h01);
    clr_overrun = 1'b1;
    @(negedge HCLK);
    clr_overrun = 1'b0;
    check("ovf_clear", o3, 0);
    // Pop exactly in the push cycle of a sixth byte
    k = -1;
    fork
      send_frame(3, 8'h06, 8, 0, 0, 1, 2'b11, 10);
      begin
        while (k < 97) begin
          @(posedge HCLK);
          k++;
        end
        @(negedge HCLK);
        rdy[3] = 1'b1;
        @(negedge HCLK);
        rdy[3] = 1'b0;
      end
    join
    wait_cycles(2);
    check("full_pp_count", c3, 4);
    check("full_pp_ovf", o3, 0);
    check("full_pp_head", d3, 8'h02);
    pop(3);
    check("fifo_e3", d3, 8'h03);
    pop(3);
    check("fifo_e4", d3, 8'h04);
    pop(3);
    check("fifo_e6", d3, 8'h06);
    pop(3);
    check("fifo_empty", c3, 0);

    // 0.3-bit glitch
    rx_line[0] = 1'b0;
    wait_cycles(3);
    rx_line[0] = 1'b1;
    check("glitch_busy", b0, 1);
    wait_cycles(20);
    check("glitch_idle", b0, 0);
    check("glitch_count", c0, 0);

    // baud_div change mid-frame
    fork
      send_frame(0, 8'h3C, 8, 0, 0, 1, 2'b11, 10);
      begin
        wait_cycles(30);
        baud_div = 16'd20;
      end
    join
    wait_cycles(3);
    check("baud10_count", c0, 1);
    check("baud10_data", d0, 8'h3C);
    pop(0);
    send_frame(0, 8'hC3, 8, 0, 0, 1, 2'b11, 20);
    wait_cycles(3);
    check("baud20_data", d0, 8'hC3);
    check("baud20_ferr", f0, 0);
    pop(0);
    baud_div = 16'd10;
    wait_cycles(5);

    // Reset during DATA
    rx_line[0] = 1'b0;
    wait_cycles(10);
    rx_line[0] = 1'b1;
    wait_cycles(35);
    check("mid_busy", b0, 1);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("midrst_busy", b0, 0);
    check("midrst_count", c0, 0);
    check("midrst_valid", v0, 0);
    wait_cycles(2);
    HRESET = 1'b0;
    wait_cycles(150);
    check("postrst_count", c0, 0);
    check("postrst_busy", b0, 0);
    send_frame(0, 8'h5A, 8, 0, 0, 1, 2'b11, 10);
    wait_cycles(3);
    check("postrst_data", d0, 8'h5A);
    check("postrst_ferr", f0, 0);
    check("postrst_cnt1", c0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
